// File: rtl/if_pipe_stage.sv
// Instruction-fetch stage: owns the PC, keeps queued plus outstanding fetches within a credit
// budget, and drives the IF/ID register. Optional macro IF_BYPASS_EN lets a response load IF/ID directly.
module if_pipe_stage #(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_hazard,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_address,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_address,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                instr_valid
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0]   LP_QD   = (CW+1)'(QDEPTH);
  localparam logic [CW-1:0] LP_FULL = CW'(QDEPTH);

  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [CW-1:0]       r_q_count, r_outstanding, r_drop_cnt;
  logic [PW-1:0]       r_q_wptr, r_q_rptr, r_t_wptr, r_t_rptr;
  logic [31:0]         r_q_instr [QDEPTH];
  logic [PC_WIDTH-1:0] r_q_pcp4  [QDEPTH];
  logic [PC_WIDTH-1:0] r_tag_pc  [QDEPTH];
  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc_plus4;
  logic                r_valid;

  logic                w_redirect, w_fire, w_drop, w_accept, w_bypass;
  logic                w_push, w_pop, w_q_empty;
  logic [CW:0]         w_used;
  logic [PC_WIDTH-1:0] w_target, w_resp_pcp4;

  assign w_redirect  = r_valid && (jump || branch_taken);
  assign w_target    = jump ? jump_address : branch_address;
  // Responses still owed for squashed fetches occupy credit until they drain.
  assign w_used      = {1'b0, r_q_count} + {1'b0, r_outstanding} + {1'b0, r_drop_cnt};
  assign imem_req    = reset && (w_used < LP_QD) && !w_redirect;
  assign imem_addr   = r_fetch_pc;
  assign w_fire      = imem_req && imem_gnt;
  assign w_drop      = imem_rvalid && (r_drop_cnt != '0);
  assign w_accept    = imem_rvalid && (r_drop_cnt == '0);
  assign w_q_empty   = (r_q_count == '0);
  assign w_resp_pcp4 = r_tag_pc[r_t_rptr] + PC_WIDTH'(4);

`ifdef IF_BYPASS_EN
  assign w_bypass = w_accept && w_q_empty && !data_hazard && !w_redirect;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && !w_redirect && !w_bypass;
  assign w_pop  = !w_redirect && !data_hazard && !w_q_empty;

  assign instr       = r_instr;
  assign pc_plus4    = r_pc_plus4;
  assign instr_valid = r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_q_count     <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_q_wptr      <= '0;
      r_q_rptr      <= '0;
      r_t_wptr      <= '0;
      r_t_rptr      <= '0;
    end else if (w_redirect) begin
      r_fetch_pc    <= w_target;
      r_q_count     <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= r_drop_cnt + r_outstanding - CW'(imem_rvalid);
      r_q_wptr      <= '0;
      r_q_rptr      <= '0;
      r_t_wptr      <= '0;
      r_t_rptr      <= '0;
    end else begin
      if (w_fire) r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
      r_q_count     <= r_q_count + CW'(w_push) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_accept);
      r_drop_cnt    <= r_drop_cnt - CW'(w_drop);
      r_q_wptr      <= r_q_wptr + PW'(w_push);
      r_q_rptr      <= r_q_rptr + PW'(w_pop);
      r_t_wptr      <= r_t_wptr + PW'(w_fire);
      r_t_rptr      <= r_t_rptr + PW'(w_accept);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_q_wptr] <= imem_rdata;
      r_q_pcp4[r_q_wptr]  <= w_resp_pcp4;
    end
    if (w_fire) r_tag_pc[r_t_wptr] <= r_fetch_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (w_redirect) begin
      r_instr <= '0;
      r_valid <= 1'b0;
    end else if (!data_hazard) begin
      if (!w_q_empty) begin
        r_instr    <= r_q_instr[r_q_rptr];
        r_pc_plus4 <= r_q_pcp4[r_q_rptr];
        r_valid    <= 1'b1;
      end else if (w_bypass) begin
        r_instr    <= imem_rdata;
        r_pc_plus4 <= w_resp_pcp4;
        r_valid    <= 1'b1;
      end else begin
        r_instr <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(w_push && !w_pop && (r_q_count == LP_FULL)));

endmodule

// File: tb/tb_if_pipe_stage.sv
// Bench for if_pipe_stage: queue-based fetch model checked every cycle plus directed literal checks.
module tb_if_pipe_stage;
  localparam int PCW = 10;
  localparam int QD  = 2;

  logic            clk = 1'b0, reset = 1'b0;
  logic            data_hazard = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [PCW-1:0]  branch_address = '0, jump_address = '0;
  logic            imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [PCW-1:0]  imem_addr, pc_plus4;
  logic [31:0]     imem_rdata = '0, instr;
  logic            instr_valid;

  int n_cmp = 0, n_bad = 0;
  int unsigned mem_lat = 1;
  int unsigned cyc = 0;

  if_pipe_stage #(.PC_WIDTH(PCW), .RESET_PC(10'h000), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset), .data_hazard(data_hazard),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .jump(jump), .jump_address(jump_address),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected event did not occur within the cycle budget", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int unsigned lim);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < lim; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  // Memory: in-order responses mem_lat cycles after grant, data = 0xA0000000 + address.
  logic [PCW-1:0] pend_addr[$];
  int unsigned    pend_due[$];
  initial begin : memory
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + mem_lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (reset && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA000_0000 + 32'(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // Model: in-flight fetch list (with squash flags), buffered words, IF/ID contents.
  typedef struct { logic [PCW-1:0] addr; bit drop; } fl_t;
  typedef struct { logic [31:0] w; logic [PCW-1:0] p4; } bw_t;
  fl_t            m_fl[$];
  bw_t            m_buf[$];
  logic [PCW-1:0] m_pc = '0, m_p4 = '0;
  logic [31:0]    m_instr = '0;
  bit             m_valid = 1'b0;

  initial begin : model_cmp
    fl_t h;
    bw_t nw, b;
    bit  have_new, redir, exp_req;
    int  credit;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_pc = '0; m_fl.delete(); m_buf.delete();
        m_instr = '0; m_p4 = '0; m_valid = 1'b0;
      end
      redir   = reset && m_valid && (jump || branch_taken);
      credit  = QD - m_buf.size() - m_fl.size();
      exp_req = reset && (credit > 0) && !redir;
      check("m_req",   32'(imem_req),    32'(exp_req));
      check("m_addr",  32'(imem_addr),   32'(m_pc));
      check("m_instr", instr,            m_instr);
      check("m_pcp4",  32'(pc_plus4),    32'(m_p4));
      check("m_valid", 32'(instr_valid), 32'(m_valid));
      if (reset) begin
        have_new = 1'b0;
        if (imem_rvalid && m_fl.size() > 0) begin
          h = m_fl.pop_front();
          if (!h.drop && !redir) begin
            nw.w = imem_rdata;
            nw.p4 = h.addr + PCW'(4);
            have_new = 1'b1;
          end
        end
        if (redir) begin
          foreach (m_fl[i]) m_fl[i].drop = 1'b1;
          m_buf.delete();
          m_pc = jump ? jump_address : branch_address;
          m_instr = '0;
          m_valid = 1'b0;
        end else begin
          if (exp_req && imem_gnt) begin
            h.addr = m_pc;
            h.drop = 1'b0;
            m_fl.push_back(h);
            m_pc = m_pc + PCW'(4);
          end
          if (!data_hazard) begin
            if (m_buf.size() > 0) begin
              b = m_buf.pop_front();
              m_instr = b.w; m_p4 = b.p4; m_valid = 1'b1;
`ifdef IF_BYPASS_EN
            end else if (have_new) begin
              m_instr = nw.w; m_p4 = nw.p4; m_valid = 1'b1;
              have_new = 1'b0;
`endif
            end else begin
              m_instr = '0; m_valid = 1'b0;
            end
          end
          if (have_new) m_buf.push_back(nw);
        end
      end
    end
  end

`ifdef IF_BYPASS_EN
  localparam int EXP_FIRST = 2;
`else
  localparam int EXP_FIRST = 3;
`endif

  initial begin : stim
    int          addrs[3];
    int          p4s[3];
    logic [31:0] ws[3];
    int          na, nv, first_k;
    bit          found;

    imem_gnt = 1'b1;
    mem_lat  = 1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_instr", instr, 32'h0);
    check("rst_pcp4",  32'(pc_plus4), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_req",   32'(imem_req), 32'h0);
    tick();
    reset = 1'b1;

    // Start-up: fetch order, first valid edge, pc_plus4 sequence
    na = 0; nv = 0; first_k = -1;
    for (int i = 0; i < 3; i++) begin addrs[i] = -1; p4s[i] = -1; ws[i] = '0; end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && na < 3) begin addrs[na] = int'(imem_addr); na++; end
      if (instr_valid && nv < 3) begin
        if (nv == 0) first_k = k;
        p4s[nv] = int'(pc_plus4); ws[nv] = instr; nv++;
      end
      tick();
    end
    check("first_valid_edge", 32'(first_k), 32'(EXP_FIRST));
    check("fetch_addr0", 32'(addrs[0]), 32'h0);
    check("fetch_addr1", 32'(addrs[1]), 32'h4);
    check("fetch_addr2", 32'(addrs[2]), 32'h8);
    check("pcp4_0", 32'(p4s[0]), 32'h4);
    check("pcp4_1", 32'(p4s[1]), 32'h8);
    check("pcp4_2", 32'(p4s[2]), 32'hC);
    check("word_0", ws[0], 32'hA000_0000);
    check("word_2", ws[2], 32'hA000_0008);

    // Stall with a full queue: requests must stop
    data_hazard = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 3) check("hazard_req_off", 32'(imem_req), 32'h0);
      tick();
    end
    data_hazard = 1'b0;
    repeat (8) tick();

    // Jump with two fetches in flight
    mem_lat = 5;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (m_valid && m_fl.size() == 1 && m_buf.size() == 0) begin
        found = 1'b1;
        data_hazard = 1'b1;
      end
    end
    if (!found) timeout("jump_setup");
    tick();
    jump = 1'b1; jump_address = 10'h100;
    tick();
    jump = 1'b0; data_hazard = 1'b0;
    wait_valid("jump_target_wait", 80);
    check("jump_instr", instr, 32'hA000_0100);
    check("jump_pcp4",  32'(pc_plus4), 32'h104);
    tick();

    // Branch and jump together, grant withheld for 5 cycles
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (instr_valid) begin
        found = 1'b1;
        branch_taken = 1'b1; jump = 1'b1;
        branch_address = 10'h040; jump_address = 10'h080;
        imem_gnt = 1'b0;
      end
    end
    if (!found) timeout("prio_setup");
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gnt_low_addr", 32'(imem_addr), 32'h80);
      if (i == 4) begin
        check("gnt_low_valid", 32'(instr_valid), 32'h0);
        check("gnt_low_req",   32'(imem_req), 32'h1);
      end
      tick();
    end
    imem_gnt = 1'b1;
    wait_valid("prio_target_wait", 40);
    check("prio_instr", instr, 32'hA000_0080);
    check("prio_pcp4",  32'(pc_plus4), 32'h84);
    tick();

    // PC wrap at the top of the address space
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (instr_valid) begin
        found = 1'b1;
        jump = 1'b1; jump_address = 10'h3FC;
      end
    end
    if (!found) timeout("wrap_setup");
    tick();
    jump = 1'b0;
    na = 0; nv = 0; addrs[0] = -1; addrs[1] = -1; p4s[0] = -1; ws[0] = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && na < 2) begin addrs[na] = int'(imem_addr); na++; end
      if (instr_valid && nv == 0) begin p4s[0] = int'(pc_plus4); ws[0] = instr; nv = 1; end
      if (na >= 2 && nv >= 1) break;
      tick();
    end
    check("wrap_addr0", 32'(addrs[0]), 32'h3FC);
    check("wrap_addr1", 32'(addrs[1]), 32'h000);
    check("wrap_instr", ws[0], 32'hA000_03FC);
    check("wrap_pcp4",  32'(p4s[0]), 32'h000);
    tick();

    // Grant withheld without redirect: queue drains to NOP
    repeat (5) tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        check("drain_valid", 32'(instr_valid), 32'h0);
        check("drain_req",   32'(imem_req), 32'h1);
      end
      tick();
    end
    imem_gnt = 1'b1;
    repeat (6) tick();

    // Reset in the middle of traffic
    mem_lat = 3;
    repeat (6) tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_pcp4",  32'(pc_plus4), 32'h0);
    check("mid_rst_valid", 32'(instr_valid), 32'h0);
    check("mid_rst_req",   32'(imem_req), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    wait_valid("restart_wait", 30);
    check("restart_instr", instr, 32'hA000_0000);
    check("restart_pcp4",  32'(pc_plus4), 32'h4);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
